// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: widths, funct3 encodings, pipeline register structs.
package riscv_pkg;

  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;

  // Load/store funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  typedef struct packed {
    logic                      valid_ex_mem;
    logic [XLEN-1:0]           alu_result;
    logic [XLEN-1:0]           rs2_data;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [2:0]                funct3;
    ctrl_t                     ctrl;
  } ex_mem_reg_t;

  typedef struct packed {
    logic                      valid_mem_wb;
    logic [XLEN-1:0]           alu_result;
    logic [XLEN-1:0]           mem_data;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    ctrl_t                     ctrl;
  } mem_wb_reg_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store lane replication / byte enables / misalignment,
// and load byte/halfword extraction with sign or zero extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            misaligned_o,
  output logic [XLEN-1:0] ldata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store side: access size comes from funct3[1:0]; undefined sizes act as a word
  always_comb begin
    be_o         = 4'b1111;
    wdata_o      = rs2_i;
    misaligned_o = 1'b0;
    case (funct3_i[1:0])
      2'b00: begin
        wdata_o = {4{rs2_i[7:0]}};
        be_o    = 4'b0001 << offset_i;
      end
      2'b01: begin
        wdata_o      = {2{rs2_i[15:0]}};
        be_o         = 4'b0011 << offset_i;
        misaligned_o = offset_i[0];
      end
      default: begin
        wdata_o      = rs2_i;
        be_o         = 4'b1111;
        misaligned_o = |offset_i;
      end
    endcase
  end

  // Load side: pick the addressed byte/halfword, extend; anything undefined returns the word
  always_comb begin
    byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_LB:   ldata_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  ldata_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   ldata_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  ldata_o = {{(XLEN-16){1'b0}}, half_sel};
      default: ldata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: one dmem request per memory op, stalls upstream while a
// transaction is outstanding, and registers the result into MEM/WB.
module mem_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  ex_mem_reg_t     ex_mem_in,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_addr,
  output logic            dmem_we,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rsp_rdata,
  output logic            mem_stall,
  output logic            misalign_exc,
  output mem_wb_reg_t     mem_wb_out
);

  mem_state_t  state_q, state_d;
  mem_wb_reg_t wb_q, wb_d;
  logic        misalign_q, misalign_d;

  logic            mem_op, is_load, misaligned;
  logic            req_raw, stall_raw;
  logic [3:0]      lane_be;
  logic [XLEN-1:0] lane_wdata, load_data;

  assign mem_op  = ex_mem_in.valid_ex_mem &
                   (ex_mem_in.ctrl.mem_read | ex_mem_in.ctrl.mem_write);
  // Both read and write set decodes as a load
  assign is_load = ex_mem_in.ctrl.mem_read;

  lsu_align u_lsu_align (
    .funct3_i     (ex_mem_in.funct3),
    .offset_i     (ex_mem_in.alu_result[1:0]),
    .rs2_i        (ex_mem_in.rs2_data),
    .rdata_i      (dmem_rsp_rdata),
    .be_o         (lane_be),
    .wdata_o      (lane_wdata),
    .misaligned_o (misaligned),
    .ldata_o      (load_data)
  );

  // Next-state, request/stall and MEM/WB capture
  always_comb begin
    state_d               = state_q;
    wb_d                  = wb_q;
    wb_d.valid_mem_wb     = 1'b0;
    misalign_d            = 1'b0;
    req_raw               = 1'b0;
    stall_raw             = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_mem_in.valid_ex_mem) begin
          if (!mem_op) begin
            wb_d.valid_mem_wb = 1'b1;
            wb_d.alu_result   = ex_mem_in.alu_result;
            wb_d.mem_data     = '0;
            wb_d.rd_addr      = ex_mem_in.rd_addr;
            wb_d.ctrl         = ex_mem_in.ctrl;
          end else if (misaligned) begin
            misalign_d = 1'b1;
          end else begin
            req_raw = 1'b1;
            if (!dmem_req_ready) begin
              stall_raw = 1'b1;
            end else if (is_load) begin
              state_d   = WAIT_RSP;
              stall_raw = 1'b1;
            end else begin
              // Store completes on the handshake itself
              wb_d.valid_mem_wb = 1'b1;
              wb_d.alu_result   = ex_mem_in.alu_result;
              wb_d.mem_data     = '0;
              wb_d.rd_addr      = ex_mem_in.rd_addr;
              wb_d.ctrl         = ex_mem_in.ctrl;
            end
          end
        end
      end
      WAIT_RSP: begin
        if (dmem_rsp_valid) begin
          state_d           = IDLE;
          wb_d.valid_mem_wb = 1'b1;
          wb_d.alu_result   = ex_mem_in.alu_result;
          wb_d.mem_data     = load_data;
          wb_d.rd_addr      = ex_mem_in.rd_addr;
          wb_d.ctrl         = ex_mem_in.ctrl;
        end else begin
          stall_raw = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, MEM/WB register and misalign pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wb_q       <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_q       <= wb_d;
      misalign_q <= misalign_d;
    end
  end

  // Qualify with reset so a memory op sitting on the input cannot leak a request during reset
  assign dmem_req_valid = req_raw & reset;
  assign mem_stall      = stall_raw & reset;
  assign dmem_we        = dmem_req_valid & ~is_load;
  assign dmem_be        = dmem_we ? lane_be : 4'b0000;
  assign dmem_addr      = {ex_mem_in.alu_result[XLEN-1:2], 2'b00};
  assign dmem_wdata     = lane_wdata;
  assign misalign_exc   = misalign_q;
  assign mem_wb_out     = wb_q;

endmodule
